block_input_conditioner: RTL and testbench

- Upstream conditioning stage that feeds the control FSM its `blocks[6:0]` and `selector[2:0]` inputs.
- Synchronises and debounces seven raw block-presence lines and one selector push-button.
- Advances a wrapping 3-bit selector once per debounced press.
- Flags any change in the debounced block vector with a one-cycle pulse, so the FSM only ever sees clean, glitch-free, clock-domain-safe inputs.

---
 rtl/block_input_conditioner.sv | 131 +++++++++++++
 tb/tb_block_input_conditioner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_input_conditioner.sv
// -----------------------------------------------------------------------------
// block_input_conditioner
//
// Conditions the raw inputs of the control FSM. There are seven block-presence
// lines and one selector push-button. Each line goes through a two-flop
// synchroniser and then through its own debounce counter. A debounced button
// press advances a wrapping selector. Any change of the debounced block vector
// is flagged with a one-cycle pulse.
//
// Ports:
//   clk            system clock, all flops on rising edge
//   reset_n        asynchronous active-low reset, clears every flop
//   blocks_raw     [6:0] asynchronous raw block-presence lines (1 = present)
//   sel_btn_raw    asynchronous raw selector button (1 = pressed)
//   blocks         [6:0] debounced block-presence vector
//   selector       [2:0] selector value, counts 0..SEL_MAX then wraps
//   blocks_changed one-cycle pulse when blocks takes a new value
//   btn_state      debounced button level / FSM state (1 = PRESSED)
// -----------------------------------------------------------------------------
module block_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int SEL_MAX         = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] blocks_raw,
   input  logic       sel_btn_raw,
   output logic [6:0] blocks,
   output logic [2:0] selector,
   output logic       blocks_changed,
   output logic       btn_state
);

   localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]         SEL_TOP  = 3'(SEL_MAX);

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } btn_fsm_t;

   // Channel 7 is the button, channels 6..0 are the block lines.
   logic [7:0]            sync_p0;
   logic [7:0]            sync_p1;
   logic [7:0][CNT_W-1:0] cnt_q;
   logic [7:0][CNT_W-1:0] cnt_d;
   logic [7:0]            deb;
   logic [7:0]            hit;
   logic [6:0]            blocks_d;
   logic [2:0]            sel_d;
   btn_fsm_t              state_q;
   btn_fsm_t              state_d;

   function automatic logic [2:0] sel_wrap_inc(input logic [2:0] v);
      return (v == SEL_TOP) ? 3'd0 : v + 3'd1;
   endfunction

   // The button FSM state doubles as the debounced button level.
   assign btn_state = (state_q == PRESSED);
   assign deb       = {btn_state, blocks};

   // ---- stage p0/p1: two-flop synchroniser ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= {sel_btn_raw, blocks_raw};
         sync_p1 <= sync_p0;
      end
   end

   // ---- debounce: count consecutive cycles the synchronised level disagrees
   // ---- with the debounced level; a hit flips the debounced level.
   always_comb begin
      cnt_d = '0;
      hit   = '0;
      for (int i = 0; i < 8; i++) begin
         if (sync_p1[i] != deb[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               hit[i]   = 1'b1;
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // A hit only occurs when the bit differs, so toggling yields the new level.
   assign blocks_d = blocks ^ hit[6:0];

   // Button FSM: a debounced rising edge advances the selector exactly once.
   always_comb begin
      state_d = state_q;
      sel_d   = selector;
      case (state_q)
         RELEASED: begin
            if (hit[7]) begin
               state_d = PRESSED;
               sel_d   = sel_wrap_inc(selector);
            end
         end
         PRESSED: begin
            if (hit[7]) begin
               state_d = RELEASED;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

   // ---- stage p2: debounced outputs, change pulse, FSM ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= '0;
         blocks         <= '0;
         blocks_changed <= 1'b0;
         selector       <= 3'd0;
         state_q        <= RELEASED;
      end else begin
         cnt_q          <= cnt_d;
         blocks         <= blocks_d;
         blocks_changed <= |hit[6:0];
         selector       <= sel_d;
         state_q        <= state_d;
      end
   end

endmodule

// File: tb/tb_block_input_conditioner.sv
module tb_block_input_conditioner;

   localparam int DEB  = 4;
   localparam int SMAX = 6;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] blocks_raw = 7'h00;
   logic       sel_btn_raw = 1'b0;
   logic [6:0] blocks;
   logic [2:0] selector;
   logic       blocks_changed;
   logic       btn_state;

   int total = 0;
   int bad   = 0;

   // Reference model state: raw inputs delayed two edges, a window of the
   // synchronised samples seen by the debouncer, and the expected outputs.
   logic [7:0] m_s1, m_s2;
   logic [7:0] hist[$];
   logic [6:0] m_blocks;
   logic [2:0] m_sel;
   logic       m_chg;
   logic       m_btn;

   block_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .SEL_MAX(SMAX)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .blocks_raw(blocks_raw),
      .sel_btn_raw(sel_btn_raw),
      .blocks(blocks),
      .selector(selector),
      .blocks_changed(blocks_changed),
      .btn_state(btn_state)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; hist.delete();
      m_blocks = '0; m_sel = '0; m_chg = 1'b0; m_btn = 1'b0;
   endtask

   // A debounced bit flips once the last DEB synchronised samples all
   // disagree with it.
   task automatic model_step();
      logic [7:0] cur;
      logic [7:0] upd;
      bit all_diff;
      cur = {m_btn, m_blocks};
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      upd = '0;
      if (hist.size() == DEB) begin
         for (int ch = 0; ch < 8; ch++) begin
            all_diff = 1'b1;
            foreach (hist[k]) if (hist[k][ch] == cur[ch]) all_diff = 1'b0;
            upd[ch] = all_diff;
         end
      end
      m_blocks = m_blocks ^ upd[6:0];
      m_chg    = |upd[6:0];
      if (upd[7]) begin
         if (!m_btn) m_sel = 3'((int'(m_sel) + 1) % (SMAX + 1));
         m_btn = ~m_btn;
      end
      m_s2 = m_s1;
      m_s1 = {sel_btn_raw, blocks_raw};
   endtask

   // One rising edge; model advances with the inputs present at that edge,
   // then the DUT is sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_clear();
      else model_step();
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; blocks_raw = 7'h7F; sel_btn_raw = 1'b1;
      model_clear();
      #1;
      for (int c = 0; c < 6; c++) begin
         total++;
         if ({blocks, selector, blocks_changed, btn_state} !== 12'h000) begin
            bad++;
            $display("FAIL reset cyc%0d: blocks=%h sel=%0d chg=%b btn=%b, expected all zero",
                     c, blocks, selector, blocks_changed, btn_state);
         end
         tick();
      end
      blocks_raw = 7'h00; sel_btn_raw = 1'b0;
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      total++;
      if ({blocks, selector, blocks_changed, btn_state} !== 12'h000) begin
         bad++;
         $display("FAIL reset_idle: blocks=%h sel=%0d chg=%b btn=%b, expected all zero",
                  blocks, selector, blocks_changed, btn_state);
      end
   endtask

   task automatic test_latency();
      blocks_raw = 7'h05;
      for (int e = 0; e < 8; e++) begin
         tick();
         total++;
         if (e < 5 && (blocks !== 7'h00 || blocks_changed !== 1'b0)) begin
            bad++;
            $display("FAIL latency_early edge%0d: blocks=%h chg=%b, expected 00 0", e, blocks, blocks_changed);
         end else if (e == 5 && (blocks !== 7'h05 || blocks_changed !== 1'b1)) begin
            bad++;
            $display("FAIL latency_edge5: blocks=%h chg=%b, expected 05 1", blocks, blocks_changed);
         end else if (e > 5 && (blocks !== 7'h05 || blocks_changed !== 1'b0)) begin
            bad++;
            $display("FAIL latency_after edge%0d: blocks=%h chg=%b, expected 05 0", e, blocks, blocks_changed);
         end
      end
   endtask

   task automatic test_glitch();
      blocks_raw = 7'h00;
      for (int c = 0; c < 10; c++) tick();
      total++;
      if (blocks !== 7'h00) begin
         bad++;
         $display("FAIL glitch_clear: blocks=%h, expected 00", blocks);
      end
      blocks_raw = 7'h08;
      for (int c = 0; c < 3; c++) tick();
      blocks_raw = 7'h00;
      for (int c = 0; c < 12; c++) begin
         total++;
         if (blocks !== 7'h00 || blocks_changed !== 1'b0) begin
            bad++;
            $display("FAIL glitch cyc%0d: blocks=%h chg=%b, expected 00 0", c, blocks, blocks_changed);
         end
         tick();
      end
   endtask

   task automatic test_selector_wrap();
      logic [2:0] prev;
      int changes;
      for (int p = 0; p < 7; p++) begin
         sel_btn_raw = 1'b1;
         for (int c = 0; c < 6; c++) tick();
         total++;
         if (selector !== 3'((p + 1) % 7) || btn_state !== 1'b1) begin
            bad++;
            $display("FAIL wrap_press%0d: sel=%0d btn=%b, expected %0d 1", p, selector, btn_state, (p + 1) % 7);
         end
         sel_btn_raw = 1'b0;
         for (int c = 0; c < 6; c++) tick();
         total++;
         if (selector !== 3'((p + 1) % 7) || btn_state !== 1'b0) begin
            bad++;
            $display("FAIL wrap_release%0d: sel=%0d btn=%b, expected %0d 0", p, selector, btn_state, (p + 1) % 7);
         end
      end
      sel_btn_raw = 1'b1;
      prev = selector;
      changes = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (selector !== prev) changes++;
         prev = selector;
      end
      total++;
      if (changes != 1 || selector !== 3'd1 || btn_state !== 1'b1) begin
         bad++;
         $display("FAIL hold_press: changes=%0d sel=%0d btn=%b, expected 1 1 1", changes, selector, btn_state);
      end
      sel_btn_raw = 1'b0;
      for (int c = 0; c < 8; c++) tick();
   endtask

   task automatic test_simultaneous();
      int pulses;
      blocks_raw = 7'h7F; sel_btn_raw = 1'b1;
      pulses = 0;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (blocks_changed === 1'b1) pulses++;
         if (e == 4) begin
            total++;
            if (blocks !== 7'h00 || selector !== 3'd1) begin
               bad++;
               $display("FAIL simul_edge4: blocks=%h sel=%0d, expected 00 1", blocks, selector);
            end
         end
         if (e == 5) begin
            total++;
            if (blocks !== 7'h7F || blocks_changed !== 1'b1 || selector !== 3'd2 || btn_state !== 1'b1) begin
               bad++;
               $display("FAIL simul_edge5: blocks=%h chg=%b sel=%0d btn=%b, expected 7f 1 2 1",
                        blocks, blocks_changed, selector, btn_state);
            end
         end
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL simul_pulses: got %0d pulses, expected 1", pulses);
      end
      sel_btn_raw = 1'b0;
      for (int c = 0; c < 8; c++) tick();
   endtask

   task automatic test_mid_reset();
      sel_btn_raw = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      total++;
      if (selector !== 3'd3 || blocks !== 7'h7F) begin
         bad++;
         $display("FAIL midrst_setup: sel=%0d blocks=%h, expected 3 7f", selector, blocks);
      end
      blocks_raw = 7'h2A;
      for (int e = 0; e < 4; e++) tick();
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      total++;
      if ({blocks, selector, blocks_changed, btn_state} !== 12'h000) begin
         bad++;
         $display("FAIL midrst_async: blocks=%h sel=%0d chg=%b btn=%b, expected all zero",
                  blocks, selector, blocks_changed, btn_state);
      end
      tick();
      tick();
      reset_n = 1'b1;
      for (int e = 0; e < 7; e++) begin
         tick();
         if (e == 4) begin
            total++;
            if (blocks !== 7'h00 || selector !== 3'd0 || btn_state !== 1'b0) begin
               bad++;
               $display("FAIL midrst_edge4: blocks=%h sel=%0d btn=%b, expected 00 0 0", blocks, selector, btn_state);
            end
         end
         if (e == 5) begin
            total++;
            if (blocks !== 7'h2A || blocks_changed !== 1'b1 || selector !== 3'd1 || btn_state !== 1'b1) begin
               bad++;
               $display("FAIL midrst_edge5: blocks=%h chg=%b sel=%0d btn=%b, expected 2a 1 1 1",
                        blocks, blocks_changed, selector, btn_state);
            end
         end
      end
   endtask

   task automatic test_random();
      int hold;
      for (int n = 0; n < 300; n++) begin
         hold = $urandom_range(1, 8);
         if ($urandom_range(0, 3) == 0) blocks_raw = 7'($urandom);
         else blocks_raw = blocks_raw ^ (7'd1 << $urandom_range(0, 6));
         if ($urandom_range(0, 2) == 0) sel_btn_raw = ~sel_btn_raw;
         for (int c = 0; c < hold; c++) begin
            tick();
            total++;
            if ({blocks, selector, blocks_changed, btn_state} !== {m_blocks, m_sel, m_chg, m_btn}) begin
               bad++;
               $display("FAIL random n%0d: blocks=%h sel=%0d chg=%b btn=%b, expected %h %0d %b %b",
                        n, blocks, selector, blocks_changed, btn_state, m_blocks, m_sel, m_chg, m_btn);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_selector_wrap();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
